// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for seq_divider.
interface seq_divider_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] numerator;
    logic [WIDTH-1:0] denominator;
    logic             ready;
    logic             valid;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;
    logic             overflow;

    modport master (
        output start, numerator, denominator,
        input  ready, valid, quotient, remainder, div_zero, overflow
    );

    modport slave (
        input  start, numerator, denominator,
        output ready, valid, quotient, remainder, div_zero, overflow
    );
endinterface

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring signed fixed-point divider, latency WIDTH+FRAC_BITS+1.
// Define DIV_SATURATE_EN to saturate the quotient on overflow instead of wrapping.
module seq_divider #(
    parameter int WIDTH     = 64,
    parameter int FRAC_BITS = 0
) (
    input logic        CLK,
    input logic        RESET_N,
    seq_divider_if.slave bus
);
    localparam int N  = WIDTH + FRAC_BITS;
    localparam int CW = $clog2(N + 1);
    localparam logic [WIDTH-1:0] MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state, state_next;

    logic [N-1:0]     dvd;
    logic [WIDTH:0]   rem;
    logic [WIDTH:0]   dsr;
    logic [WIDTH-1:0] num_raw;
    logic             num_neg, den_neg, den_zero;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] quotient_r, remainder_r;
    logic             valid_r, div_zero_r, overflow_r;

    logic [WIDTH-1:0] num_abs, den_abs;
    logic [WIDTH+1:0] shifted;
    logic             ge;
    logic [WIDTH:0]   diff;
    logic             q_neg, ovf_fix;
    logic [N:0]       lim;
    logic [WIDTH-1:0] q_fix, r_fix;

    always_comb begin
        num_abs = bus.numerator[WIDTH-1]   ? -bus.numerator   : bus.numerator;
        den_abs = bus.denominator[WIDTH-1] ? -bus.denominator : bus.denominator;
        shifted = {rem, dvd[N-1]};
        ge      = shifted >= {1'b0, dsr};
        // Only used when ge, where the true difference is below dsr and fits.
        diff    = shifted[WIDTH:0] - dsr;
    end

    always_comb begin
        q_neg = num_neg ^ den_neg;
        lim   = (N+1)'(1) << (WIDTH - 1);
        if (!q_neg) begin
            lim = lim - (N+1)'(1);
        end
        ovf_fix = {1'b0, dvd} > lim;
        q_fix   = q_neg ? -dvd[WIDTH-1:0] : dvd[WIDTH-1:0];
`ifdef DIV_SATURATE_EN
        if (ovf_fix) begin
            q_fix = q_neg ? MIN : MAX;
        end
`endif
        r_fix = num_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
        if (den_zero) begin
            q_fix   = num_neg ? MIN : MAX;
            r_fix   = num_raw;
            ovf_fix = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = CALC;
            CALC:    if (count == CW'(N - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            dvd         <= '0;
            rem         <= '0;
            dsr         <= '0;
            num_raw     <= '0;
            num_neg     <= 1'b0;
            den_neg     <= 1'b0;
            den_zero    <= 1'b0;
            count       <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            valid_r     <= 1'b0;
            div_zero_r  <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    dvd      <= N'(num_abs) << FRAC_BITS;
                    rem      <= '0;
                    dsr      <= {1'b0, den_abs};
                    num_raw  <= bus.numerator;
                    num_neg  <= bus.numerator[WIDTH-1];
                    den_neg  <= bus.denominator[WIDTH-1];
                    den_zero <= (bus.denominator == '0);
                    count    <= '0;
                end
                CALC: begin
                    rem   <= ge ? diff : shifted[WIDTH:0];
                    dvd   <= {dvd[N-2:0], ge};
                    count <= count + 1'b1;
                end
                FIX: begin
                    quotient_r  <= q_fix;
                    remainder_r <= r_fix;
                    div_zero_r  <= den_zero;
                    overflow_r  <= ovf_fix;
                    valid_r     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.ready     = (state == IDLE);
        bus.valid     = valid_r;
        bus.quotient  = quotient_r;
        bus.remainder = remainder_r;
        bus.div_zero  = div_zero_r;
        bus.overflow  = overflow_r;
    end
endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider: 64-bit integer and 32-bit Q16.16 instances.
module tb_seq_divider;
    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    always #5 CLK = ~CLK;

    seq_divider_if #(.WIDTH(64)) b64();
    seq_divider_if #(.WIDTH(32)) b32();

    seq_divider #(.WIDTH(64), .FRAC_BITS(0)) dut64 (.CLK(CLK), .RESET_N(RESET_N), .bus(b64));
    seq_divider #(.WIDTH(32), .FRAC_BITS(16)) dut32 (.CLK(CLK), .RESET_N(RESET_N), .bus(b32));

    localparam logic [63:0] MAX64 = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
`ifdef DIV_SATURATE_EN
    localparam logic [63:0] QOVF64 = MAX64;
    localparam logic [63:0] QOVF32_POS = 64'h7FFF_FFFF;
    localparam logic [63:0] QOVF32_NEG = 64'h8000_0000;
`else
    localparam logic [63:0] QOVF64 = MIN64;
    localparam logic [63:0] QOVF32_POS = 64'h0;
    localparam logic [63:0] QOVF32_NEG = 64'h0;
`endif

    typedef struct {
        logic [63:0] num;
        logic [63:0] den;
        logic [63:0] q;
        logic [63:0] r;
        logic        dz;
        logic        ov;
    } vec_t;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start64(input logic [63:0] num, input logic [63:0] den);
        @(negedge CLK);
        b64.start = 1'b1;
        b64.numerator = num;
        b64.denominator = den;
        @(posedge CLK);
        #1;
        b64.start = 1'b0;
        chk("ready_drop64", 64'(b64.ready), 64'd0);
    endtask

    task automatic start32(input logic [31:0] num, input logic [31:0] den);
        @(negedge CLK);
        b32.start = 1'b1;
        b32.numerator = num;
        b32.denominator = den;
        @(posedge CLK);
        #1;
        b32.start = 1'b0;
        chk("ready_drop32", 64'(b32.ready), 64'd0);
    endtask

    task automatic wait64(output int lat);
        lat = 0;
        do begin
            @(posedge CLK);
            #1;
            lat++;
        end while (!b64.valid && lat < 300);
    endtask

    task automatic wait32(output int lat);
        lat = 0;
        do begin
            @(posedge CLK);
            #1;
            lat++;
        end while (!b32.valid && lat < 300);
    endtask

    task automatic check64(input string tag, input int lat, input int exp_lat, input vec_t v);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_q"}, b64.quotient, v.q);
        chk({tag, "_r"}, b64.remainder, v.r);
        chk({tag, "_dz"}, 64'(b64.div_zero), 64'(v.dz));
        chk({tag, "_ov"}, 64'(b64.overflow), 64'(v.ov));
    endtask

    task automatic check32(input string tag, input int lat, input vec_t v);
        chk({tag, "_lat"}, 64'(lat), 64'd49);
        chk({tag, "_q"}, 64'(b32.quotient), v.q);
        chk({tag, "_r"}, 64'(b32.remainder), v.r);
        chk({tag, "_dz"}, 64'(b32.div_zero), 64'(v.dz));
        chk({tag, "_ov"}, 64'(b32.overflow), 64'(v.ov));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[$];
        vec_t v32[$];
        vec_t v;
        int lat;
        int saw_valid;

        vecs.push_back('{64'sd100,  64'sd7,   64'sd14,  64'sd2,  1'b0, 1'b0});
        vecs.push_back('{-64'sd100, 64'sd7,   -64'sd14, -64'sd2, 1'b0, 1'b0});
        vecs.push_back('{64'sd100,  -64'sd7,  -64'sd14, 64'sd2,  1'b0, 1'b0});
        vecs.push_back('{-64'sd100, -64'sd7,  64'sd14,  -64'sd2, 1'b0, 1'b0});
        vecs.push_back('{64'sd100,  64'sd0,   MAX64,    64'sd100, 1'b1, 1'b0});
        vecs.push_back('{-64'sd5,   64'sd0,   MIN64,    -64'sd5,  1'b1, 1'b0});
        vecs.push_back('{64'sd0,    64'sd0,   MAX64,    64'sd0,   1'b1, 1'b0});
        vecs.push_back('{MIN64,     -64'sd1,  QOVF64,   64'sd0,   1'b0, 1'b1});
        vecs.push_back('{MIN64,     64'sd1,   MIN64,    64'sd0,   1'b0, 1'b0});
        vecs.push_back('{MAX64,     -64'sd1,  64'h8000_0000_0000_0001, 64'sd0, 1'b0, 1'b0});
        vecs.push_back('{MIN64,     MIN64,    64'sd1,   64'sd0,   1'b0, 1'b0});
        vecs.push_back('{MIN64,     64'sd2,   64'hC000_0000_0000_0000, 64'sd0, 1'b0, 1'b0});
        vecs.push_back('{MAX64,     MIN64,    64'sd0,   MAX64,    1'b0, 1'b0});
        vecs.push_back('{64'sd7,    64'sd100, 64'sd0,   64'sd7,   1'b0, 1'b0});
        vecs.push_back('{-64'sd7,   64'sd100, 64'sd0,   -64'sd7,  1'b0, 1'b0});
        vecs.push_back('{-64'sd1000000007, 64'sd1000, -64'sd1000000, -64'sd7, 1'b0, 1'b0});

        v32.push_back('{64'h0003_0000, 64'h0002_0000, 64'h0001_8000, 64'h0, 1'b0, 1'b0});
        v32.push_back('{64'hFFFD_0000, 64'h0002_0000, 64'hFFFE_8000, 64'h0, 1'b0, 1'b0});
        v32.push_back('{64'h0001_0000, 64'h0003_0000, 64'h0000_5555, 64'h0001_0000, 1'b0, 1'b0});
        v32.push_back('{64'h7FFF_0000, 64'h0000_0001, QOVF32_POS, 64'h0, 1'b0, 1'b1});
        v32.push_back('{64'h8001_0000, 64'h0000_0001, QOVF32_NEG, 64'h0, 1'b0, 1'b1});
        v32.push_back('{64'h0005_0000, 64'h0, 64'h7FFF_FFFF, 64'h0005_0000, 1'b1, 1'b0});

        b64.start = 1'b0; b64.numerator = '0; b64.denominator = '0;
        b32.start = 1'b0; b32.numerator = '0; b32.denominator = '0;

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_ready", 64'(b64.ready), 64'd1);
        chk("rst_valid", 64'(b64.valid), 64'd0);
        chk("rst_q", b64.quotient, 64'd0);
        chk("rst_r", b64.remainder, 64'd0);
        chk("rst_flags", {62'd0, b64.div_zero, b64.overflow}, 64'd0);
        @(negedge CLK);
        RESET_N = 1'b1;

        foreach (vecs[i]) begin
            start64(vecs[i].num, vecs[i].den);
            wait64(lat);
            check64($sformatf("v64_%0d", i), lat, 65, vecs[i]);
        end

        foreach (v32[i]) begin
            start32(v32[i].num[31:0], v32[i].den[31:0]);
            wait32(lat);
            check32($sformatf("v32_%0d", i), lat, v32[i]);
            @(posedge CLK);
            #1;
            chk("valid_pulse32", 64'(b32.valid), 64'd0);
        end

        // Starts during CALC are ignored; operand changes after accept have no effect.
        start64(64'sd20, 64'sd3);
        b64.numerator = 64'sd999;
        b64.denominator = 64'sd5;
        for (int k = 1; k <= 10; k++) begin
            @(posedge CLK);
            #1;
            b64.start = (k == 5);
            if (k == 5) begin
                b64.numerator = 64'sd1000;
                b64.denominator = 64'sd1;
            end
        end
        b64.start = 1'b0;
        wait64(lat);
        v = '{64'sd20, 64'sd3, 64'sd6, 64'sd2, 1'b0, 1'b0};
        check64("busy_ign", lat, 55, v);
        @(posedge CLK);
        #1;
        chk("busy_ign_no2nd", 64'(b64.valid), 64'd0);

        // Back-to-back: second start accepted in the valid cycle.
        start64(64'sd1000, 64'sd3);
        wait64(lat);
        v = '{64'sd1000, 64'sd3, 64'sd333, 64'sd1, 1'b0, 1'b0};
        check64("b2b_a", lat, 65, v);
        start64(-64'sd50, 64'sd8);
        chk("b2b_pulse", 64'(b64.valid), 64'd0);
        chk("b2b_hold_q", b64.quotient, 64'sd333);
        wait64(lat);
        v = '{-64'sd50, 64'sd8, -64'sd6, -64'sd2, 1'b0, 1'b0};
        check64("b2b_b", lat, 65, v);

        // Reset mid-operation aborts without a valid pulse.
        start64(64'sd100, 64'sd7);
        repeat (29) @(posedge CLK);
        #1;
        RESET_N = 1'b0;
        #1;
        chk("abort_ready", 64'(b64.ready), 64'd1);
        chk("abort_valid", 64'(b64.valid), 64'd0);
        chk("abort_q", b64.quotient, 64'd0);
        chk("abort_r", b64.remainder, 64'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        saw_valid = 0;
        repeat (80) begin
            @(posedge CLK);
            #1;
            if (b64.valid) saw_valid++;
        end
        chk("abort_no_valid", 64'(saw_valid), 64'd0);
        start64(64'sd9, 64'sd3);
        wait64(lat);
        v = '{64'sd9, 64'sd3, 64'sd3, 64'sd0, 1'b0, 1'b0};
        check64("after_abort", lat, 65, v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
